// File: rtl/calc2_pkg.sv
// rtl/calc2_pkg.sv - shared types, widths and result helper for the calc2 port responder
package calc2_pkg;

  localparam int CMD_W   = 4;
  localparam int TAG_W   = 2;
  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int NTAGS   = 1 << TAG_W;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_OP2
  } state_e;

  // cmd kept as raw bits so invalid codes travel through the queue untouched
  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } req_t;

  typedef struct packed {
    resp_e             resp;
    logic [DATA_W-1:0] data;
  } result_t;

  function automatic result_t calc_result(input req_t r);
    result_t         res;
    logic [DATA_W:0] sum;
    res.resp = RESP_ERR;
    res.data = '0;
    sum      = {1'b0, r.op1} + {1'b0, r.op2};
    case (r.cmd)
      CMD_ADD: if (!sum[DATA_W]) begin
        res.resp = RESP_OK;
        res.data = sum[DATA_W-1:0];
      end
      CMD_SUB: if (r.op1 >= r.op2) begin
        res.resp = RESP_OK;
        res.data = r.op1 - r.op2;
      end
      CMD_SHL: begin
        res.resp = RESP_OK;
        res.data = r.op1 << r.op2[SHAMT_W-1:0];
      end
      CMD_SHR: begin
        res.resp = RESP_OK;
        res.data = r.op1 >> r.op2[SHAMT_W-1:0];
      end
      default: ;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/calc2_req_fifo.sv
// rtl/calc2_req_fifo.sv - request FIFO with synchronous push/pop and full/empty flags
module calc2_req_fifo
  import calc2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  req_t push_data_i,
  input  logic pop_i,
  output req_t pop_data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  req_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/calc2_port_responder.sv
// rtl/calc2_port_responder.sv - two-cycle request receiver, tag guard, queued ALU responder
module calc2_port_responder
  import calc2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [0:CMD_W-1]  req_cmd_in,
  input  logic [0:TAG_W-1]  req_tag_in,
  input  logic [0:DATA_W-1] req_data_in,
  output logic [0:1]        out_response,
  output logic [0:DATA_W-1] out_data,
  output logic [0:TAG_W-1]  out_tag
);

  logic [CMD_W-1:0]  cmd_w;
  logic [TAG_W-1:0]  tag_w;
  logic [DATA_W-1:0] data_w;
  state_e            state_q;
  req_t              hold_q, push_req, pop_req;
  logic              push_en, fifo_full, fifo_empty;
  logic [NTAGS-1:0]  mask_q, mask_d, set_mask, clr_mask;
  result_t           res;
  resp_e             resp_q, resp_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TAG_W-1:0]  tag_q, tag_d;

  assign cmd_w  = req_cmd_in;
  assign tag_w  = req_tag_in;
  assign data_w = req_data_in;

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (cmd_w != CMD_NOP) begin
          hold_q.cmd <= cmd_w;
          hold_q.tag <= tag_w;
          hold_q.op1 <= data_w;
          state_q    <= ST_WAIT_OP2;
        end
        ST_WAIT_OP2: state_q <= ST_IDLE;
        default:     state_q <= ST_IDLE;
      endcase
    end
  end

  // a tag stays outstanding through the cycle its response is on the outputs
  always_comb begin
    push_req     = hold_q;
    push_req.op2 = data_w;
    push_en      = (state_q == ST_WAIT_OP2) && !mask_q[hold_q.tag] && !fifo_full;
    set_mask     = '0;
    clr_mask     = '0;
    if (push_en) set_mask[hold_q.tag] = 1'b1;
    if (resp_q != RESP_NONE) clr_mask[tag_q] = 1'b1;
    mask_d = (mask_q & ~clr_mask) | set_mask;
  end

  calc2_req_fifo #(.DEPTH(DEPTH)) u_req_fifo (
    .clk_i       (c_clk),
    .rst_ni      (reset),
    .push_i      (push_en),
    .push_data_i (push_req),
    .pop_i       (!fifo_empty),
    .pop_data_o  (pop_req),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    res    = calc_result(pop_req);
    resp_d = RESP_NONE;
    data_d = '0;
    tag_d  = '0;
    if (!fifo_empty) begin
      resp_d = res.resp;
      data_d = res.data;
      tag_d  = pop_req.tag;
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      mask_q <= '0;
      resp_q <= RESP_NONE;
      data_q <= '0;
      tag_q  <= '0;
    end else begin
      mask_q <= mask_d;
      resp_q <= resp_d;
      data_q <= data_d;
      tag_q  <= tag_d;
    end
  end

  assign out_response = resp_q;
  assign out_data     = data_q;
  assign out_tag      = tag_q;

endmodule

// File: tb/tb_calc2_port_responder.sv
// tb/tb_calc2_port_responder.sv - self-checking bench for calc2_port_responder
module tb_calc2_port_responder;

  logic        c_clk;
  logic        reset;
  logic [0:3]  req_cmd_in;
  logic [0:1]  req_tag_in;
  logic [0:31] req_data_in;
  logic [0:1]  out_response;
  logic [0:31] out_data;
  logic [0:1]  out_tag;

  calc2_port_responder #(.DEPTH(4)) dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req_cmd_in   (req_cmd_in),
    .req_tag_in   (req_tag_in),
    .req_data_in  (req_data_in),
    .out_response (out_response),
    .out_data     (out_data),
    .out_tag      (out_tag)
  );

  typedef struct {
    int          cyc;
    int          resp;
    int          tag;
    logic [31:0] data;
  } ev_t;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  ev_t obs_q[$];
  ev_t exp_q[$];
  int  last_r[4];
  int  last_resp;

  initial begin
    c_clk = 1'b0;
    forever #5 c_clk = ~c_clk;
  end

  always @(posedge c_clk) cyc <= cyc + 1;

  always @(negedge c_clk) begin
    if (out_response != 0 || out_data != 0 || out_tag != 0)
      obs_q.push_back('{cyc, int'(out_response), int'(out_tag), out_data});
  end

  task automatic model_clear();
    for (int i = 0; i < 4; i++) last_r[i] = -100;
    last_resp = -100;
  endtask

  // Reference: arrival-ordered service, one per cycle, earliest three cycles after the command
  task automatic model_request(input int cmd, input int tag, input logic [31:0] op1,
                               input logic [31:0] op2, input int c);
    ev_t         e;
    logic [63:0] sum;
    int          r;
    if (last_r[tag] >= c + 1) return;
    r = (c + 3 > last_resp + 1) ? c + 3 : last_resp + 1;
    sum = {32'd0, op1} + {32'd0, op2};
    e.cyc = r; e.tag = tag; e.resp = 2; e.data = 32'd0;
    case (cmd)
      1: if (sum <= 64'h0000_0000_FFFF_FFFF) begin e.resp = 1; e.data = sum[31:0]; end
      2: if (op1 >= op2) begin e.resp = 1; e.data = op1 - op2; end
      5: begin e.resp = 1; e.data = op1 << (op2 % 32); end
      6: begin e.resp = 1; e.data = op1 >> (op2 % 32); end
      default: ;
    endcase
    exp_q.push_back(e);
    last_r[tag] = r;
    last_resp = r;
  endtask

  task automatic send(input int cmd, input int tag, input logic [31:0] op1,
                      input logic [31:0] op2, input bit track);
    req_cmd_in  = cmd[3:0];
    req_tag_in  = tag[1:0];
    req_data_in = op1;
    if (track) model_request(cmd, tag, op1, op2, cyc);
    @(negedge c_clk);
    req_cmd_in  = 4'($urandom_range(0, 15));
    req_tag_in  = 2'($urandom_range(0, 3));
    req_data_in = op2;
    @(negedge c_clk);
    req_cmd_in  = 4'd0;
  endtask

  task automatic idle(input int n);
    req_cmd_in = 4'd0;
    repeat (n) @(negedge c_clk);
  endtask

  task automatic flush(input string name);
    ev_t o, e;
    int  n;
    idle(12);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s count: got %0d responses, expected %0d", name, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      o = obs_q[i];
      e = exp_q[i];
      n_checks++;
      if (o.cyc !== e.cyc || o.resp !== e.resp || o.tag !== e.tag || o.data !== e.data) begin
        n_fail++;
        $display("FAIL %s #%0d: got cyc=%0d resp=%0d tag=%0d data=%h, expected cyc=%0d resp=%0d tag=%0d data=%h",
                 name, i, o.cyc, o.resp, o.tag, o.data, e.cyc, e.resp, e.tag, e.data);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string name);
    n_checks++;
    if (out_response !== 2'd0 || out_data !== 32'd0 || out_tag !== 2'd0) begin
      n_fail++;
      $display("FAIL %s: got resp=%0d data=%h tag=%0d, expected all 0", name, out_response, out_data, out_tag);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_cmd_in = 0; req_tag_in = 0; req_data_in = 0;
    model_clear();
    repeat (3) @(negedge c_clk);
    check_outputs_zero("reset_state");
    reset = 1'b1;
  endtask

  task automatic test_add();
    send(1, 1, 32'h5, 32'h7, 1'b0);
    n_checks++;
    if (out_response !== 2'd0) begin
      n_fail++; $display("FAIL add_early: got resp=%0d, expected 0", out_response);
    end
    @(negedge c_clk);
    n_checks++;
    if (out_response !== 2'd1 || out_data !== 32'h0000000C || out_tag !== 2'd1) begin
      n_fail++;
      $display("FAIL add_n3: got resp=%0d data=%h tag=%0d, expected 1/0000000c/1", out_response, out_data, out_tag);
    end
    @(negedge c_clk);
    check_outputs_zero("add_held_one_cycle");
    idle(4);
    obs_q.delete();
  endtask

  task automatic test_arith();
    send(1, 1, 32'h0000_0005, 32'h0000_0007, 1'b1); idle(1);
    send(1, 2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1); idle(1);
    send(2, 3, 32'h3, 32'h4, 1'b1);                 idle(1);
    send(2, 0, 32'h10, 32'h10, 1'b1);               idle(1);
    send(5, 1, 32'h1, 32'h24, 1'b1);                idle(1);
    send(6, 2, 32'h8000_0000, 32'd31, 1'b1);        idle(1);
    send(3, 0, 32'h1234_5678, 32'h1, 1'b1);
    flush("arith");
  endtask

  task automatic test_back_to_back();
    send(1, 0, 32'd10, 32'd1, 1'b1);
    send(2, 1, 32'd10, 32'd1, 1'b1);
    send(5, 2, 32'd10, 32'd1, 1'b1);
    send(1, 2, 32'd99, 32'd1, 1'b1);
    send(6, 3, 32'd10, 32'd1, 1'b1);
    flush("back_to_back");
  endtask

  task automatic test_reset_mid();
    send(1, 1, 32'd2, 32'd3, 1'b0);
    @(negedge c_clk);
    n_checks++;
    if (out_response !== 2'd1) begin
      n_fail++; $display("FAIL pre_async_reset: got resp=%0d, expected 1", out_response);
    end
    reset = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    obs_q.delete();
    repeat (2) @(negedge c_clk);
    reset = 1'b1;

    req_cmd_in = 4'd1; req_tag_in = 2'd2; req_data_in = 32'd40;
    @(negedge c_clk);
    req_cmd_in = 4'd0; req_data_in = 32'd2;
    reset = 1'b0;
    #1;
    check_outputs_zero("reset_op2_cycle");
    repeat (2) @(negedge c_clk);
    reset = 1'b1;

    send(2, 3, 32'd9, 32'd1, 1'b0);
    req_cmd_in = 4'd1; req_tag_in = 2'd0; req_data_in = 32'd1;
    reset = 1'b0;
    repeat (2) @(negedge c_clk);
    req_cmd_in = 4'd0;
    reset = 1'b1;
    model_clear();
    flush("no_resp_after_reset");

    send(1, 2, 32'h100, 32'h23, 1'b1);
    flush("add_after_reset");
  endtask

  task automatic test_random();
    int          cmd, tag, gap;
    logic [31:0] op1, op2;
    for (int i = 0; i < 60; i++) begin
      cmd = $urandom_range(1, 15);
      if ($urandom_range(0, 1) == 1) cmd = (i % 2 == 0) ? $urandom_range(1, 2) : $urandom_range(5, 6);
      tag = $urandom_range(0, 3);
      op1 = $urandom;
      op2 = $urandom;
      case ($urandom_range(0, 3))
        0: op1 = 32'hFFFF_FFFF - $urandom_range(0, 3);
        1: op2 = op1;
        default: ;
      endcase
      send(cmd, tag, op1, op2, 1'b1);
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap);
    end
    flush("random");
  endtask

  initial begin
    test_reset();
    test_add();
    test_arith();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
